// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared opcodes, state encoding and width defaults
package alu_exec_unit_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_exec_unit_mul8_iter.sv
// rtl/alu_exec_unit_mul8_iter.sv - 8x8 shift-add multiplier, one multiplier bit per cycle
module mul8_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        ready
);

    logic [15:0] acc;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [3:0]  count;

    // The load edge already consumes b[0], so seven more edges finish the product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= b[0] ? {8'b0, a} : 16'd0;
            mcand  <= {7'b0, a, 1'b0};
            mplier <= {1'b0, b[7:1]};
            count  <= 4'd1;
        end else if (count != 4'd0 && count != 4'd8) begin
            acc    <= acc + (mplier[0] ? mcand : 16'd0);
            mcand  <= {mcand[14:0], 1'b0};
            mplier <= {1'b0, mplier[7:1]};
            count  <= count + 4'd1;
        end
    end

    assign product = acc;
    assign ready   = (count == 4'd8);

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU stage: read, execute, write back to the register file
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    opcode,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] read_addr_1,
    output logic [AW-1:0] read_addr_2,
    input  logic [DW-1:0] read_data_1,
    input  logic [DW-1:0] read_data_2,
    output logic [AW-1:0] write_addr,
    output logic [DW-1:0] write_data,
    output logic          reg_write_n,
    output logic          zero_flag,
    output logic          carry_flag
);

    state_t        state, state_next;
    logic [2:0]    op_q;
    logic [DW-1:0] a_q, b_q;
    logic          carry_q;
    logic [DW-1:0] alu_res;
    logic          alu_carry;
    logic [DW:0]   wide;
    logic [15:0]   mul_product;
    logic          mul_ready;

    mul8_iter u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (state == READ && op_q == OP_MUL),
        .a       (read_data_1),
        .b       (read_data_2),
        .product (mul_product),
        .ready   (mul_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    if (op_q != OP_MUL || mul_ready) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign done        = (state == WRITE);
    assign reg_write_n = (state != WRITE);

    // Shifts carry out the last bit moved past the word edge; a zero shift leaves it clear.
    always_comb begin
        wide      = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                wide      = {1'b0, a_q} + {1'b0, b_q};
                alu_res   = wide[DW-1:0];
                alu_carry = wide[DW];
            end
            OP_SUB: begin
                wide      = {1'b0, a_q} - {1'b0, b_q};
                alu_res   = wide[DW-1:0];
                alu_carry = wide[DW];
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                wide      = {1'b0, a_q} << b_q[2:0];
                alu_res   = wide[DW-1:0];
                alu_carry = wide[DW];
            end
            OP_SHR: begin
                wide      = {a_q, 1'b0} >> b_q[2:0];
                alu_res   = wide[DW:1];
                alu_carry = wide[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            read_addr_1 <= '0;
            read_addr_2 <= '0;
            write_addr  <= '0;
            write_data  <= '0;
            zero_flag   <= 1'b0;
            carry_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q        <= opcode;
                    read_addr_1 <= rs1;
                    read_addr_2 <= rs2;
                    write_addr  <= rd;
                end
                READ: begin
                    a_q <= read_data_1;
                    b_q <= read_data_2;
                end
                EXEC: if (op_q != OP_MUL) begin
                    write_data <= alu_res;
                    carry_q    <= alu_carry;
                end else if (mul_ready) begin
                    write_data <= mul_product[DW-1:0];
                    carry_q    <= |mul_product[15:8];
                end
                WRITE: begin
                    zero_flag  <= (write_data == '0);
                    carry_flag <= carry_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed-vector bench for alu_exec_unit with a register file model
module tb_alu_exec_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic [2:0] rd = 3'd0, rs1 = 3'd0, rs2 = 3'd0;
    logic       busy, done, reg_write_n, zero_flag, carry_flag;
    logic [2:0] read_addr_1, read_addr_2, write_addr;
    logic [7:0] read_data_1, read_data_2, write_data;

    logic [7:0] rf [8];
    logic [7:0] exp_rf [8];
    logic       pl_en = 1'b0;
    logic [2:0] pl_addr = 3'd0;
    logic [7:0] pl_data = 8'd0;

    int errors = 0;
    int checks = 0;
    int wr_pulses = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .busy        (busy),
        .done        (done),
        .read_addr_1 (read_addr_1),
        .read_addr_2 (read_addr_2),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .reg_write_n (reg_write_n),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag)
    );

    always @(posedge clk) begin
        if (pl_en)             rf[pl_addr]    <= pl_data;
        else if (!reg_write_n) rf[write_addr] <= write_data;
    end

    assign read_data_1 = rf[read_addr_1];
    assign read_data_2 = rf[read_addr_2];

    always @(negedge clk) if (!reg_write_n) wr_pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d; exp_rf[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, output int lat, output int bcnt);
        @(negedge clk);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) bcnt++;
        @(negedge clk);
    endtask

    task automatic run_check(input string name, input logic [2:0] op, input logic [2:0] d,
                             input logic [2:0] s1, input logic [2:0] s2, input logic [7:0] exp_val,
                             input logic exp_z, input logic exp_c, input int exp_lat);
        int lat, bcnt, p0;
        p0 = wr_pulses;
        issue(op, d, s1, s2, lat, bcnt);
        exp_rf[d] = exp_val;
        chk({name, "_rf"}, rf[d], exp_val);
        chk({name, "_zero"}, zero_flag, exp_z);
        chk({name, "_carry"}, carry_flag, exp_c);
        chk({name, "_done_lat"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, bcnt, exp_lat);
        chk({name, "_wr_pulses"}, wr_pulses - p0, 1);
    endtask

    initial begin
        int p0, first_done, second_done;

        repeat (3) @(negedge clk);
        chk("rst_busy_in_reset", busy, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_reg_write_n", reg_write_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_zero", zero_flag, 1'b0);
        chk("rst_carry", carry_flag, 1'b0);
        chk("rst_write_data", write_data, 8'h00);
        chk("rst_write_addr", write_addr, 3'd0);
        chk("rst_read_addr_1", read_addr_1, 3'd0);

        for (int i = 0; i < 8; i++) poke(3'(i), 8'h00);

        poke(3'd1, 8'h7F); poke(3'd2, 8'h01);
        run_check("add_7f_01", 3'b000, 3'd3, 3'd1, 3'd2, 8'h80, 1'b0, 1'b0, 3);
        poke(3'd1, 8'hFF);
        run_check("add_ff_01", 3'b000, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 1'b1, 3);
        poke(3'd5, 8'h05); poke(3'd6, 8'h07);
        run_check("sub_05_07", 3'b001, 3'd7, 3'd5, 3'd6, 8'hFE, 1'b0, 1'b1, 3);
        poke(3'd1, 8'h81);
        run_check("shl_81_1", 3'b101, 3'd3, 3'd1, 3'd2, 8'h02, 1'b0, 1'b1, 3);
        run_check("shr_81_0", 3'b110, 3'd3, 3'd1, 3'd0, 8'h81, 1'b0, 1'b0, 3);
        poke(3'd1, 8'h0C); poke(3'd2, 8'h0B);
        run_check("mul_0c_0b", 3'b111, 3'd3, 3'd1, 3'd2, 8'h84, 1'b0, 1'b0, 10);
        poke(3'd1, 8'h10); poke(3'd2, 8'h10);
        run_check("mul_10_10", 3'b111, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 1'b1, 10);
        poke(3'd4, 8'h03);
        run_check("add_rd_eq_rs", 3'b000, 3'd4, 3'd4, 3'd4, 8'h06, 1'b0, 1'b0, 3);

        // start pulses in EXEC and in WRITE must both be dropped
        p0 = wr_pulses;
        @(negedge clk);
        opcode = 3'b000; rd = 3'd0; rs1 = 3'd4; rs2 = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        opcode = 3'b001; rd = 3'd5; start = 1'b1;
        @(negedge clk);
        chk("busy_ign_done", done, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_ign_idle", busy, 1'b0);
        repeat (6) @(negedge clk);
        exp_rf[0] = 8'h0C;
        chk("busy_ign_still_idle", busy, 1'b0);
        chk("busy_ign_pulses", wr_pulses - p0, 1);
        chk("busy_ign_r0", rf[0], 8'h0C);

        // back-to-back with start held: ADD R1=R4+R0, then XOR R2=R1^R4
        p0 = wr_pulses; first_done = 0; second_done = 0;
        @(negedge clk);
        opcode = 3'b000; rd = 3'd1; rs1 = 3'd4; rs2 = 3'd0; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin opcode = 3'b100; rd = 3'd2; rs1 = 3'd1; rs2 = 3'd4; end
            if (c == 5) start = 1'b0;
            if (done && first_done == 0) first_done = c;
            else if (done) second_done = c;
        end
        exp_rf[1] = 8'h12; exp_rf[2] = 8'h14;
        chk("b2b_first_done", first_done, 3);
        chk("b2b_second_done", second_done, 7);
        chk("b2b_pulses", wr_pulses - p0, 2);
        chk("b2b_r1", rf[1], 8'h12);
        chk("b2b_r2", rf[2], 8'h14);
        chk("b2b_idle", busy, 1'b0);

        // reset in the 5th EXEC cycle of a MUL
        p0 = wr_pulses;
        @(negedge clk);
        opcode = 3'b111; rd = 3'd6; rs1 = 3'd1; rs2 = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmid_busy_before", busy, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_reg_write_n", reg_write_n, 1'b1);
        chk("rstmid_done", done, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("rstmid_pulses", wr_pulses - p0, 0);
        chk("rstmid_idle", busy, 1'b0);
        chk("rstmid_zero", zero_flag, 1'b0);
        chk("rstmid_carry", carry_flag, 1'b0);

        for (int i = 0; i < 8; i++) chk($sformatf("rf_model_r%0d", i), rf[i], exp_rf[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
